// File: rtl/contador_updown_param.sv
// Parametrised up/down modulo counter with input synchronisers,
// optional edge detection, synchronous load and carry/borrow pulses.
module contador_updown_param #(
    parameter int WIDTH     = 3,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 7,
    parameter int WRAP      = 1,
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [1:0]       EDGE_MASK = (EDGE_MODE != 0) ? 2'b11 : 2'b00;

    // bit 0 carries up, bit 1 carries down
    logic [1:0] s1, s2, s3;
    // arm: input seen low since reset, so a level held across reset never steps
    logic [1:0] arm;
    logic       live;
    logic [1:0] req;
    logic       inc_req, dec_req;

    logic [WIDTH:0]   ext, din_x;
    logic [WIDTH-1:0] out_n;
    logic             carry_n, borrow_n;

    assign req     = arm & s2 & ~(s3 & EDGE_MASK);
    assign inc_req = req[0];
    assign dec_req = req[1];
    assign ext     = {1'b0, out};
    assign din_x   = {1'b0, din};

    always_comb begin
        out_n    = out;
        carry_n  = 1'b0;
        borrow_n = 1'b0;
        if (load) begin
            if (din_x < MIN_X)
                out_n = MIN_W;
            else if (din_x > MAX_X)
                out_n = MAX_W;
            else
                out_n = din;
        end else if (EN && inc_req && !dec_req) begin
            if (ext >= MAX_X) begin
                if (WRAP != 0) begin
                    out_n   = MIN_W;
                    carry_n = 1'b1;
                end
            end else begin
                out_n = out + 1'b1;
            end
        end else if (EN && dec_req && !inc_req) begin
            if (ext <= MIN_X) begin
                if (WRAP != 0) begin
                    out_n    = MAX_W;
                    borrow_n = 1'b1;
                end
            end else begin
                out_n = out - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 2'b00;
            s2     <= 2'b00;
            s3     <= 2'b00;
            arm    <= 2'b00;
            live   <= 1'b0;
            out    <= MIN_W;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            s1     <= {down, up};
            s2     <= s1;
            s3     <= s2;
            live   <= 1'b1;
            arm    <= arm | ({2{live}} & ~s1);
            out    <= out_n;
            carry  <= carry_n;
            borrow <= borrow_n;
        end
    end

endmodule

// File: tb/tb_contador_updown_param.sv
// Directed bench for contador_updown_param: vector table plus
// hand-written reset, latency, saturation and level-mode sequences.
module tb_contador_updown_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       EN = 1'b1;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       load = 1'b0;
    logic [2:0] din = 3'd0;

    logic [2:0] out0, out1, out3;
    logic       c0, b0, c1, b1, c3, b3;

    int total = 0;
    int bad = 0;
    int n_c1 = 0, n_b1 = 0, n_c3 = 0, n_both = 0;

    always #5 clk = ~clk;

    contador_updown_param u0 (
        .clk(clk), .rst(rst), .EN(EN), .up(up), .down(down),
        .load(load), .din(din), .out(out0), .carry(c0), .borrow(b0)
    );

    contador_updown_param #(.MIN_VAL(2), .MAX_VAL(5), .WRAP(0)) u1 (
        .clk(clk), .rst(rst), .EN(EN), .up(up), .down(down),
        .load(load), .din(din), .out(out1), .carry(c1), .borrow(b1)
    );

    contador_updown_param #(.EDGE_MODE(0)) u3 (
        .clk(clk), .rst(rst), .EN(EN), .up(up), .down(down),
        .load(load), .din(din), .out(out3), .carry(c3), .borrow(b3)
    );

    always @(negedge clk) begin
        if (c1) n_c1 = n_c1 + 1;
        if (b1) n_b1 = n_b1 + 1;
        if (c3) n_c3 = n_c3 + 1;
        if ((c0 && b0) || (c1 && b1) || (c3 && b3)) n_both = n_both + 1;
    end

    typedef struct {
        logic       ld;
        logic [2:0] d;
        logic       en;
        logic       u;
        logic       dn;
        logic [2:0] eo;
        logic       ec;
        logic       eb;
    } vec_t;

    vec_t tbl[29];

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        up = 1'b0;
        down = 1'b0;
        load = 1'b0;
        EN = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
    endtask

    task automatic pulse(input bit is_up);
        if (is_up) up = 1'b1;
        else down = 1'b1;
        step();
        up = 1'b0;
        down = 1'b0;
        repeat (3) step();
    endtask

    task automatic set_row(input int i, input logic ld, input logic [2:0] d,
                           input logic en, input logic u, input logic dn,
                           input logic [2:0] eo, input logic ec,
                           input logic eb);
        tbl[i] = '{ld, d, en, u, dn, eo, ec, eb};
    endtask

    initial begin
        set_row(0,  1, 6, 0, 0, 0, 6, 0, 0);
        set_row(1,  0, 0, 1, 1, 0, 6, 0, 0);
        set_row(2,  0, 0, 1, 0, 0, 6, 0, 0);
        set_row(3,  0, 0, 1, 0, 0, 7, 0, 0);
        set_row(4,  0, 0, 1, 1, 0, 7, 0, 0);
        set_row(5,  0, 0, 1, 0, 0, 7, 0, 0);
        set_row(6,  0, 0, 1, 0, 0, 0, 1, 0);
        set_row(7,  0, 0, 1, 0, 0, 0, 0, 0);
        set_row(8,  0, 0, 1, 0, 1, 0, 0, 0);
        set_row(9,  0, 0, 1, 0, 0, 0, 0, 0);
        set_row(10, 0, 0, 1, 0, 0, 7, 0, 1);
        set_row(11, 0, 0, 1, 0, 0, 7, 0, 0);
        set_row(12, 0, 0, 1, 1, 1, 7, 0, 0);
        set_row(13, 0, 0, 1, 0, 0, 7, 0, 0);
        set_row(14, 0, 0, 1, 0, 0, 7, 0, 0);
        set_row(15, 0, 0, 1, 0, 0, 7, 0, 0);
        set_row(16, 0, 0, 0, 1, 0, 7, 0, 0);
        set_row(17, 0, 0, 0, 1, 0, 7, 0, 0);
        set_row(18, 0, 0, 0, 1, 0, 7, 0, 0);
        set_row(19, 0, 0, 1, 1, 0, 7, 0, 0);
        set_row(20, 0, 0, 1, 0, 0, 7, 0, 0);
        set_row(21, 0, 0, 1, 0, 0, 7, 0, 0);
        set_row(22, 1, 3, 0, 0, 0, 3, 0, 0);
        set_row(23, 1, 2, 1, 0, 0, 2, 0, 0);
        set_row(24, 0, 0, 1, 1, 0, 2, 0, 0);
        set_row(25, 0, 0, 1, 0, 0, 2, 0, 0);
        set_row(26, 1, 5, 1, 0, 0, 5, 0, 0);
        set_row(27, 0, 0, 1, 0, 0, 5, 0, 0);
        set_row(28, 0, 0, 1, 0, 0, 5, 0, 0);

        // reset and asynchronous reset mid-count
        do_reset();
        check("rst_out", out0, 0);
        check("rst_carry", c0, 0);
        check("rst_borrow", b0, 0);
        check("rst_out_sat", out1, 2);
        repeat (5) pulse(1'b1);
        check("count5", out0, 5);
        up = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_out", out0, 0);
        check("async_rst_cb", {c0, b0}, 0);
        #2;
        rst = 1'b1;
        repeat (8) step();
        check("held_up_no_step", out0, 0);
        up = 1'b0;
        repeat (2) step();
        pulse(1'b1);
        check("fresh_edge_step", out0, 1);

        // edge mode: latency and one step per held level
        do_reset();
        up = 1'b1;
        step();
        check("lat_edge1", out0, 0);
        step();
        check("lat_edge2", out0, 0);
        step();
        check("lat_edge3", out0, 1);
        repeat (97) step();
        check("held_100", out0, 1);
        up = 1'b0;
        repeat (2) step();
        repeat (3) pulse(1'b1);
        check("three_pulses", out0, 4);

        // vector table on the default instance
        do_reset();
        foreach (tbl[i]) begin
            load = tbl[i].ld;
            din = tbl[i].d;
            EN = tbl[i].en;
            up = tbl[i].u;
            down = tbl[i].dn;
            step();
            check($sformatf("vec%0d_out", i), out0, tbl[i].eo);
            check($sformatf("vec%0d_cb", i), {c0, b0}, {tbl[i].ec, tbl[i].eb});
        end
        load = 1'b0;
        up = 1'b0;
        down = 1'b0;
        EN = 1'b1;

        // saturating instance: bounds and load clamp
        do_reset();
        n_c1 = 0;
        n_b1 = 0;
        pulse(1'b0);
        check("sat_low", out1, 2);
        load = 1'b1;
        din = 3'd5;
        step();
        load = 1'b0;
        check("sat_load5", out1, 5);
        pulse(1'b1);
        check("sat_high", out1, 5);
        check("sat_no_carry", n_c1, 0);
        check("sat_no_borrow", n_b1, 0);
        load = 1'b1;
        din = 3'd7;
        step();
        check("clamp_hi", out1, 5);
        check("clamp_hi_wrapinst", out0, 7);
        din = 3'd0;
        step();
        check("clamp_lo", out1, 2);
        din = 3'd4;
        step();
        load = 1'b0;
        check("clamp_mid", out1, 4);

        // level mode: up held for 10 cycles
        do_reset();
        n_c3 = 0;
        up = 1'b1;
        repeat (10) step();
        up = 1'b0;
        repeat (4) step();
        check("level_10", out3, 2);
        check("level_carries", n_c3, 1);

        check("never_both", n_both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
